// File: rtl/cs_config_pkg.sv
// Configuration constants and rotation helper for the cyclic-shift erasure codec.
// Shared by the top-level encoder and the decoder sub-module.
package cs_config_pkg;

  localparam int CFG_2_3_M     = 2;
  localparam int CFG_2_3_K     = 3;
  localparam int CFG_2_3_WIDTH = 4;
  localparam int CFG_2_3_SHIFT [1][2] = '{'{0, 1}};
  localparam int CFG_2_3_INV   [1][2] = '{'{0, 3}};

  localparam int CFG_3_5_M     = 3;
  localparam int CFG_3_5_K     = 5;
  localparam int CFG_3_5_WIDTH = 4;
  localparam int CFG_3_5_SHIFT [2][3] = '{'{0, 1, 2}, '{0, 2, 1}};
  localparam int CFG_3_5_INV   [2][3] = '{'{0, 3, 2}, '{0, 2, 3}};

  // Circular left rotate of the low w bits of x by s; callers slice the result.
  function automatic logic [63:0] rotl(input logic [63:0] x, input int s, input int w);
    logic [63:0] mask;
    logic [63:0] r;
    int sh;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    sh   = (w > 0) ? (s % w) : 0;
    if (sh == 0) begin
      r = x & mask;
    end else begin
      r = ((x << sh) | ((x & mask) >> (w - sh))) & mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/cs_decoder.sv
// Erasure decoder: counts erased data symbols, selects the lowest surviving
// parity and recovers a single lost data symbol, with one output register stage.
module cs_decoder
  import cs_config_pkg::*;
#(
  parameter int M = CFG_2_3_M,
  parameter int K = CFG_2_3_K,
  parameter int WIDTH = CFG_2_3_WIDTH,
  parameter int SHIFT_TABLE [K-M][M] = CFG_2_3_SHIFT,
  parameter int INV_SHIFT [K-M][M] = CFG_2_3_INV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [K-1:0]     erasure,
  input  logic [WIDTH-1:0] coded_in [K],
  output logic             valid_out,
  output logic             ok,
  output logic [WIDTH-1:0] data_out [M]
);

  localparam int P = K - M;

  int               e_cnt;
  int               e_idx;
  int               p_sel;
  logic             p_found;
  logic             ok_n;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] data_n [M];

  function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x, input int s);
    logic [63:0] r;
    r = rotl(64'(x), s, WIDTH);
    return r[WIDTH-1:0];
  endfunction

  // Erasure analysis, parity selection and recovery of the single erased symbol.
  always_comb begin
    e_cnt   = 0;
    e_idx   = 0;
    p_sel   = 0;
    p_found = 1'b0;
    for (int i = 0; i < M; i++) begin
      e_cnt = e_cnt + (erasure[i] ? 1 : 0);
      e_idx = erasure[i] ? i : e_idx;
    end
    for (int j = P - 1; j >= 0; j--) begin
      p_sel   = erasure[M+j] ? p_sel : j;
      p_found = p_found | ~erasure[M+j];
    end
    t = '0;
    for (int j = 0; j < P; j++) begin
      t = (j == p_sel) ? coded_in[M+j] : t;
    end
    for (int i = 0; i < M; i++) begin
      t = t ^ ((i != e_idx) ? rot(coded_in[i], SHIFT_TABLE[p_sel][i]) : '0);
    end
    ok_n = (e_cnt == 0) || ((e_cnt == 1) && p_found);
    for (int i = 0; i < M; i++) begin
      if (!erasure[i]) begin
        data_n[i] = coded_in[i];
      end else if (ok_n) begin
        data_n[i] = rot(t, INV_SHIFT[p_sel][i]);
      end else begin
        data_n[i] = '0;
      end
    end
  end

  // Result register: data and ok hold between requests, valid pulses per request.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      ok        <= 1'b0;
      for (int i = 0; i < M; i++) data_out[i] <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        ok <= ok_n;
        for (int i = 0; i < M; i++) data_out[i] <= data_n[i];
      end
    end
  end

endmodule

// File: rtl/cs_codec.sv
// Systematic cyclic-shift erasure codec: inline encoder plus independent decoder,
// each path a single register stage with no backpressure.
module cs_codec
  import cs_config_pkg::*;
#(
  parameter int M = CFG_2_3_M,
  parameter int K = CFG_2_3_K,
  parameter int WIDTH = CFG_2_3_WIDTH,
  parameter int SHIFT_TABLE [K-M][M] = CFG_2_3_SHIFT,
  parameter int INV_SHIFT [K-M][M] = CFG_2_3_INV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_valid_in,
  input  logic [WIDTH-1:0] enc_data_in [M],
  output logic             enc_valid_out,
  output logic [WIDTH-1:0] enc_coded_out [K],
  input  logic             dec_valid_in,
  input  logic [K-1:0]     dec_erasure,
  input  logic [WIDTH-1:0] dec_coded_in [K],
  output logic             dec_valid_out,
  output logic             dec_ok,
  output logic [WIDTH-1:0] dec_data_out [M]
);

  localparam int P = K - M;

  logic [WIDTH-1:0] enc_next [K];
  logic [WIDTH-1:0] acc;

  function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x, input int s);
    logic [63:0] r;
    r = rotl(64'(x), s, WIDTH);
    return r[WIDTH-1:0];
  endfunction

  // Systematic part passes through; each parity XORs the rotated data symbols.
  always_comb begin
    acc = '0;
    for (int i = 0; i < M; i++) enc_next[i] = enc_data_in[i];
    for (int j = 0; j < P; j++) begin
      acc = '0;
      for (int i = 0; i < M; i++) acc = acc ^ rot(enc_data_in[i], SHIFT_TABLE[j][i]);
      enc_next[M+j] = acc;
    end
  end

  // Coded output register; holds until the next encode request.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_valid_out <= 1'b0;
      for (int i = 0; i < K; i++) enc_coded_out[i] <= '0;
    end else begin
      enc_valid_out <= enc_valid_in;
      if (enc_valid_in) begin
        for (int i = 0; i < K; i++) enc_coded_out[i] <= enc_next[i];
      end
    end
  end

  cs_decoder #(
    .M(M),
    .K(K),
    .WIDTH(WIDTH),
    .SHIFT_TABLE(SHIFT_TABLE),
    .INV_SHIFT(INV_SHIFT)
  ) u_decoder (
    .clk(clk),
    .rst(rst),
    .valid_in(dec_valid_in),
    .erasure(dec_erasure),
    .coded_in(dec_coded_in),
    .valid_out(dec_valid_out),
    .ok(dec_ok),
    .data_out(dec_data_out)
  );

endmodule

// File: tb/tb_cs_codec.sv
// Scoreboard bench for cs_codec in the (2,3) and (3,5) configurations; the
// reference decoder recovers erased symbols by exhaustive search over candidates.
module tb_cs_codec;
  import cs_config_pkg::*;

  typedef int vec_t [5];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       e0_vin, e0_vout, d0_vin, d0_vout, d0_ok;
  logic [3:0] e0_din [2];
  logic [3:0] e0_cout [3];
  logic [2:0] d0_era;
  logic [3:0] d0_cin [3];
  logic [3:0] d0_dout [2];

  logic       e1_vin, e1_vout, d1_vin, d1_vout, d1_ok;
  logic [3:0] e1_din [3];
  logic [3:0] e1_cout [5];
  logic [4:0] d1_era;
  logic [3:0] d1_cin [5];
  logic [3:0] d1_dout [3];

  cs_codec u0 (
    .clk(clk), .rst(rst),
    .enc_valid_in(e0_vin), .enc_data_in(e0_din),
    .enc_valid_out(e0_vout), .enc_coded_out(e0_cout),
    .dec_valid_in(d0_vin), .dec_erasure(d0_era), .dec_coded_in(d0_cin),
    .dec_valid_out(d0_vout), .dec_ok(d0_ok), .dec_data_out(d0_dout)
  );

  cs_codec #(
    .M(CFG_3_5_M), .K(CFG_3_5_K), .WIDTH(CFG_3_5_WIDTH),
    .SHIFT_TABLE(CFG_3_5_SHIFT), .INV_SHIFT(CFG_3_5_INV)
  ) u1 (
    .clk(clk), .rst(rst),
    .enc_valid_in(e1_vin), .enc_data_in(e1_din),
    .enc_valid_out(e1_vout), .enc_coded_out(e1_cout),
    .dec_valid_in(d1_vin), .dec_erasure(d1_era), .dec_coded_in(d1_cin),
    .dec_valid_out(d1_vout), .dec_ok(d1_ok), .dec_data_out(d1_dout)
  );

  int cfg_m [2] = '{2, 3};
  int cfg_k [2] = '{3, 5};
  int shf [2][2][3] = '{'{'{0, 1, 0}, '{0, 0, 0}}, '{'{0, 1, 2}, '{0, 2, 1}}};

  logic [19:0] eq0 [$];
  logic [19:0] eq1 [$];
  logic [12:0] dq0 [$];
  logic [12:0] dq1 [$];
  int n_tests = 0;
  int n_fail = 0;
  logic chk_zero = 1'b0;
  logic chk_end = 1'b0;

  function automatic int rotl_m(int x, int s, int w);
    int r = 0;
    for (int b = 0; b < w; b++) if (x[b]) r = r | (1 << ((b + s) % w));
    return r;
  endfunction

  function automatic vec_t encode_m(int cfg, vec_t d);
    vec_t c;
    int m = cfg_m[cfg];
    c = '{0, 0, 0, 0, 0};
    for (int i = 0; i < m; i++) c[i] = d[i];
    for (int j = 0; j < cfg_k[cfg] - m; j++)
      for (int i = 0; i < m; i++) c[m+j] = c[m+j] ^ rotl_m(d[i], shf[cfg][j][i], 4);
    return c;
  endfunction

  function automatic logic [19:0] pack(vec_t v, int n);
    logic [19:0] r = '0;
    int t;
    for (int i = 0; i < n; i++) begin
      t = v[i];
      r[4*i +: 4] = t[3:0];
    end
    return r;
  endfunction

  // Expected {ok, data}: the erased symbol is whichever value re-encodes to the parity.
  function automatic logic [12:0] decode_m(int cfg, int era, vec_t c);
    vec_t d, cand;
    int m = cfg_m[cfg];
    int ne = 0, e = 0, hit = 0;
    logic ok = 1'b0, done = 1'b0;
    logic [12:0] r;
    d = '{0, 0, 0, 0, 0};
    for (int i = 0; i < m; i++) begin
      d[i] = era[i] ? 0 : c[i];
      if (era[i]) begin ne++; e = i; end
    end
    if (ne == 0) ok = 1'b1;
    else if (ne == 1) begin
      for (int j = 0; j < cfg_k[cfg] - m; j++) begin
        if (!done && !era[m+j]) begin
          done = 1'b1;
          for (int v = 0; v < 16; v++) begin
            d[e] = v;
            cand = encode_m(cfg, d);
            if (cand[m+j] == c[m+j]) hit = v;
          end
          d[e] = hit;
          ok = 1'b1;
        end
      end
      if (!done) d[e] = 0;
    end
    r = pack(d, m);
    r[12] = ok;
    return r;
  endfunction

  task automatic enc_req(int cfg, vec_t d);
    vec_t c;
    c = encode_m(cfg, d);
    if (cfg == 0) begin
      e0_vin = 1'b1;
      for (int i = 0; i < 2; i++) e0_din[i] = 4'(d[i]);
      eq0.push_back(pack(c, 3));
    end else begin
      e1_vin = 1'b1;
      for (int i = 0; i < 3; i++) e1_din[i] = 4'(d[i]);
      eq1.push_back(pack(c, 5));
    end
  endtask

  // Erased positions carry random garbage that the decoder must ignore.
  task automatic dec_req(int cfg, int era, vec_t c_in);
    vec_t c;
    c = c_in;
    for (int i = 0; i < cfg_k[cfg]; i++) if (era[i]) c[i] = int'($urandom_range(0, 15));
    if (cfg == 0) begin
      d0_vin = 1'b1;
      d0_era = 3'(era);
      for (int i = 0; i < 3; i++) d0_cin[i] = 4'(c[i]);
      dq0.push_back(decode_m(0, era, c));
    end else begin
      d1_vin = 1'b1;
      d1_era = 5'(era);
      for (int i = 0; i < 5; i++) d1_cin[i] = 4'(c[i]);
      dq1.push_back(decode_m(1, era, c));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e0_vin = 1'b0; d0_vin = 1'b0; e1_vin = 1'b0; d1_vin = 1'b0;
  endtask

  task automatic zero_check();
    chk_zero = 1'b1;
    @(negedge clk);
    #1;
    chk_zero = 1'b0;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 5; i++) v[i] = int'($urandom_range(0, 15));
    return v;
  endfunction

  // Monitor: pops the scoreboard whenever a path presents a result.
  always @(negedge clk) begin
    logic [19:0] eg, ee;
    logic [12:0] dg, de;
    logic [63:0] z;
    if (e0_vout) begin
      eg = {8'h00, e0_cout[2], e0_cout[1], e0_cout[0]};
      n_tests++;
      if (eq0.size() == 0) begin n_fail++; $display("FAIL enc0_extra got %h", eg); end
      else begin
        ee = eq0.pop_front();
        if (eg !== ee) begin n_fail++; $display("FAIL enc0 got %h exp %h", eg, ee); end
      end
    end
    if (e1_vout) begin
      eg = {e1_cout[4], e1_cout[3], e1_cout[2], e1_cout[1], e1_cout[0]};
      n_tests++;
      if (eq1.size() == 0) begin n_fail++; $display("FAIL enc1_extra got %h", eg); end
      else begin
        ee = eq1.pop_front();
        if (eg !== ee) begin n_fail++; $display("FAIL enc1 got %h exp %h", eg, ee); end
      end
    end
    if (d0_vout) begin
      dg = {d0_ok, 4'h0, d0_dout[1], d0_dout[0]};
      n_tests++;
      if (dq0.size() == 0) begin n_fail++; $display("FAIL dec0_extra got %h", dg); end
      else begin
        de = dq0.pop_front();
        if (dg !== de) begin n_fail++; $display("FAIL dec0 got %h exp %h", dg, de); end
      end
    end
    if (d1_vout) begin
      dg = {d1_ok, d1_dout[2], d1_dout[1], d1_dout[0]};
      n_tests++;
      if (dq1.size() == 0) begin n_fail++; $display("FAIL dec1_extra got %h", dg); end
      else begin
        de = dq1.pop_front();
        if (dg !== de) begin n_fail++; $display("FAIL dec1 got %h exp %h", dg, de); end
      end
    end
    if (chk_zero) begin
      z = {6'(0), e0_vout, d0_vout, d0_ok, e1_vout, d1_vout, d1_ok,
           e0_cout[2], e0_cout[1], e0_cout[0], d0_dout[1], d0_dout[0],
           e1_cout[4], e1_cout[3], e1_cout[2], e1_cout[1], e1_cout[0],
           d1_dout[2], d1_dout[1], d1_dout[0]};
      n_tests++;
      if (z !== 64'd0) begin n_fail++; $display("FAIL reset_zero got %h exp 0", z); end
    end
    if (chk_end) begin
      n_tests++;
      if (eq0.size() + eq1.size() + dq0.size() + dq1.size() != 0) begin
        n_fail++;
        $display("FAIL pending got %0d exp 0", eq0.size() + eq1.size() + dq0.size() + dq1.size());
      end
    end
  end

  initial begin
    vec_t c;
    rst = 1'b1;
    e0_vin = 1'b0; d0_vin = 1'b0; e1_vin = 1'b0; d1_vin = 1'b0;
    d0_era = 3'd0; d1_era = 5'd0;
    for (int i = 0; i < 2; i++) e0_din[i] = 4'd0;
    for (int i = 0; i < 3; i++) begin e1_din[i] = 4'd0; d0_cin[i] = 4'd0; end
    for (int i = 0; i < 5; i++) d1_cin[i] = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    zero_check();
    rst = 1'b0;

    // Directed vectors, (2,3): A,5 -> {A,5,0}; F,0 -> {F,0,F}.
    step(); enc_req(0, '{10, 5, 0, 0, 0}); dec_req(0, 0, '{10, 5, 0, 0, 0});
    step(); enc_req(0, '{15, 0, 0, 0, 0}); dec_req(0, 1, '{10, 5, 0, 0, 0});
    step(); dec_req(0, 2, '{10, 5, 0, 0, 0});
    step(); dec_req(0, 4, '{10, 5, 0, 0, 0});
    step(); dec_req(0, 3, '{10, 5, 0, 0, 0});
    step(); dec_req(0, 1, '{15, 0, 15, 0, 0});
    // Directed vectors, (3,5): A,5,3 -> {A,5,3,C,9}; F,E,D -> {F,E,D,5,F}.
    step(); enc_req(1, '{10, 5, 3, 0, 0}); dec_req(1, 0, '{10, 5, 3, 12, 9});
    step(); enc_req(1, '{15, 14, 13, 0, 0}); dec_req(1, 1, '{10, 5, 3, 12, 9});
    step(); dec_req(1, 8, '{10, 5, 3, 12, 9});
    step(); dec_req(1, 2, '{15, 14, 13, 5, 15});
    step(); dec_req(1, 25, '{15, 14, 13, 5, 15});

    // Randomized traffic, including back-to-back and simultaneous requests.
    repeat (400) begin
      step();
      for (int cfg = 0; cfg < 2; cfg++) begin
        if ($urandom_range(0, 3) != 0) enc_req(cfg, rand_vec());
        if ($urandom_range(0, 3) != 0) begin
          c = ($urandom_range(0, 1) == 1) ? encode_m(cfg, rand_vec()) : rand_vec();
          dec_req(cfg, int'($urandom_range(0, (1 << cfg_k[cfg]) - 1)), c);
        end
      end
    end

    // Reset over held nonzero outputs, with requests asserted during reset.
    step();
    enc_req(0, '{10, 5, 0, 0, 0}); dec_req(0, 0, '{10, 5, 0, 0, 0});
    enc_req(1, '{10, 5, 3, 0, 0}); dec_req(1, 0, '{10, 5, 3, 12, 9});
    step();
    rst = 1'b1;
    e0_vin = 1'b1; d0_vin = 1'b1; e1_vin = 1'b1; d1_vin = 1'b1;
    @(posedge clk);
    #1;
    zero_check();
    rst = 1'b0;
    e0_vin = 1'b0; d0_vin = 1'b0; e1_vin = 1'b0; d1_vin = 1'b0;

    repeat (3) step();
    chk_end = 1'b1;
    @(negedge clk);
    #1;
    chk_end = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cs_codec.md
Name: cs_codec

Overview:
- Systematic cyclic-shift erasure codec over M data symbols of WIDTH bits, producing K coded symbols.
- Coded symbols 0..M-1 are the data; symbols M..K-1 are parities.
- Each parity is the XOR of per-symbol left rotations of the data.
- Contains an independent encoder path and decoder path. It sits between packet framing and the link.
- The decoder recovers any single erased data symbol from one surviving parity.

Parameters:
- M, 2, number of data symbols.
- K, 3, number of coded symbols (K > M); P = K-M parities.
- WIDTH, 4, bits per symbol.
- SHIFT_TABLE, {{0,1}}, int array [P][M]; left-rotate amount of data i in parity j, range 0..WIDTH-1.
- INV_SHIFT, {{0,3}}, int array [P][M]; right-rotate equivalent, equal to (WIDTH - SHIFT_TABLE[j][i]) mod WIDTH, stored as a left-rotate amount.

Ports:
- clk, in, 1, clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- enc_valid_in, in, 1, encode request.
- enc_data_in, in, [M][WIDTH], unpacked array of data symbols.
- enc_valid_out, out, 1, one-cycle pulse when coded output updates.
- enc_coded_out, out, [K][WIDTH], registered coded symbols.
- dec_valid_in, in, 1, decode request.
- dec_erasure, in, K, bit i = coded symbol i lost.
- dec_coded_in, in, [K][WIDTH], received symbols; values at erased positions are ignored.
- dec_valid_out, out, 1, one-cycle pulse when decode result updates.
- dec_ok, out, 1, data output is the exact original.
- dec_data_out, out, [M][WIDTH], registered recovered data.

Behaviour:
- Reset, while rst=1 at a clock edge: every output is 0.
- rotl(x,s) is the circular left rotate of a WIDTH-bit value by s.
- Encoder, latency 1:
  - On an edge with enc_valid_in=1: enc_coded_out[i] <= data[i] for i<M.
  - enc_coded_out[M+j] <= XOR over i of rotl(data[i], SHIFT_TABLE[j][i]).
  - enc_valid_out <= 1 on that edge, otherwise 0.
  - enc_coded_out holds its value until the next request.
- Decoder, latency 1, registered; outputs hold between requests:
  - E = number of erased data bits (dec_erasure[M-1:0]).
  - E=0: dec_data_out = dec_coded_in[0..M-1]; ok=1; parity erasures are irrelevant.
  - E=1, erased index e, at least one unerased parity: pick the lowest-index unerased parity j.
  - Compute t = coded[M+j] XOR (XOR over i≠e of rotl(coded[i], SHIFT_TABLE[j][i])).
  - Recovered data[e] = rotl(t, INV_SHIFT[j][e]). Other data pass through; ok=1.
  - E=1 with all parities erased, or E≥2: ok=0.
  - When ok=0, unerased data symbols pass through and erased data symbols are output as 0.
  - dec_valid_out <= 1 on the request edge, otherwise 0.
- Encoder and decoder are fully independent; simultaneous requests are both serviced.
- Back-to-back requests every cycle are supported; there is no backpressure.
- Reset asserted mid-operation clears outputs; pending results are discarded.
- Decode is fully combinational from registered-input-free logic, so there is a single register stage per path.

Decomposition:
- cs_config_pkg holds the configuration constants:
  - CFG_2_3_M=2, CFG_2_3_K=3, CFG_2_3_WIDTH=4, CFG_2_3_SHIFT={{0,1}}, CFG_2_3_INV={{0,3}}.
  - CFG_3_5_M=3, CFG_3_5_K=5, CFG_3_5_WIDTH=4, CFG_3_5_SHIFT={{0,1,2},{0,2,1}}, CFG_3_5_INV={{0,3,2},{0,2,3}}.
  - A rotl function.
- One sub-module is natural: cs_decoder (erasure analysis, parity select, recovery), instantiated beside the inline encoder.

Test Plan:
- (2,3), data A,5, no erasure -> coded {A,5,0}; decode ok=1, data {A,5}; valid_out pulses 1 cycle after each valid_in.
- (2,3), erasure 001 / 010 / 100 on coded {A,5,0} -> ok=1, data {A,5} each time. Also data F,0 encodes to {F,0,F}; erasure 001 -> {F,0}, ok=1.
- (2,3), erasure 011 -> ok=0, data {0,0}.
- (3,5), data A,5,3 -> coded {A,5,3,C,9}. Erasures 00000, 00001 and 01000 -> ok=1, data {A,5,3}.
- (3,5), data F,E,D -> P0=5; erasure 00010 -> ok=1, data {F,E,D}. Erasure 11001 (d0 and both parities) -> ok=0.
- Reset asserted while outputs hold nonzero values -> all outputs 0 on the next edge; enc_valid_in=1 during reset is ignored.
